// File: rtl/cpu_pkg.sv
// Shared types for the hazard scoreboard: halt FSM states, scoreboard entry
// layout and forward-select encoding.
package cpu_pkg;

    // Widest register address a scoreboard entry can hold.
    localparam int SB_RA_W_MAX = 8;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } sb_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic                   is_load;
        logic [SB_RA_W_MAX-1:0] dst;
    } sb_entry_t;

    // Code 0 selects the register-file operand; entry k forwards as k + FWD_NEAREST.
    localparam int FWD_REGFILE = 0;
    localparam int FWD_NEAREST = 1;

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// Priority search over the in-flight writes for one source operand; the
// youngest writer (lowest index) wins.
module sb_match
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int RA_W     = 4,
    parameter int ZERO_REG = 1,
    parameter int FS_W     = $clog2(DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [RA_W-1:0]  src_addr,
    input  logic             src_used,
    output logic             hit,
    output logic [FS_W-1:0]  k,
    output logic             is_load
);

    logic [SB_RA_W_MAX-1:0] src_ext;
    logic                   src_ok;

    assign src_ext = SB_RA_W_MAX'(src_addr);
    assign src_ok  = src_used && ((ZERO_REG == 0) || (src_addr != '0));

    // The WB entry is left out of the search: the register file writes through.
    always_comb begin
        hit     = 1'b0;
        k       = '0;
        is_load = 1'b0;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (src_ok && entries[i].valid && entries[i].we && (entries[i].dst == src_ext)) begin
                hit     = 1'b1;
                k       = FS_W'(i);
                is_load = entries[i].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard, forwarding and halt-drain controller sitting beside
// the ID stage of the pipelined CPU.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int RA_W       = 4,
    parameter int LOAD_READY = 1,
    parameter int ZERO_REG   = 1,
    parameter int FS_W       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_src0_addr,
    input  logic [RA_W-1:0] id_src1_addr,
    input  logic            id_src0_used,
    input  logic            id_src1_used,
    input  logic [RA_W-1:0] id_dst_addr,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            id_is_hlt,
    input  logic            ex_br_taken,
    output logic            stall_if_id,
    output logic            bubble_ex,
    output logic            flush_if_id,
    output logic [FS_W-1:0] fwd_sel0_ex,
    output logic [FS_W-1:0] fwd_sel1_ex,
    output logic            hlt
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_state_t        state, next_state;
    sb_entry_t        sb [DEPTH];
    sb_entry_t        id_entry;
    logic [CNT_W-1:0] drain_cnt;
    logic             hit0, hit1, ld0, ld1;
    logic [FS_W-1:0]  k0, k1;
    logic             load_use;
    logic             accept;

    sb_match #(.DEPTH(DEPTH), .RA_W(RA_W), .ZERO_REG(ZERO_REG), .FS_W(FS_W)) u_match0 (
        .entries  (sb),
        .src_addr (id_src0_addr),
        .src_used (id_src0_used),
        .hit      (hit0),
        .k        (k0),
        .is_load  (ld0)
    );

    sb_match #(.DEPTH(DEPTH), .RA_W(RA_W), .ZERO_REG(ZERO_REG), .FS_W(FS_W)) u_match1 (
        .entries  (sb),
        .src_addr (id_src1_addr),
        .src_used (id_src1_used),
        .hit      (hit1),
        .k        (k1),
        .is_load  (ld1)
    );

    // A halt never writes a register, so it enters the scoreboard with we cleared.
    assign id_entry = '{valid:   1'b1,
                        we:      id_we & ~id_is_hlt,
                        is_load: id_is_load,
                        dst:     SB_RA_W_MAX'(id_dst_addr)};

    assign load_use = id_valid &&
                      ((hit0 && ld0 && (int'(k0) < LOAD_READY)) ||
                       (hit1 && ld1 && (int'(k1) < LOAD_READY)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // A taken branch beats both a load-use stall and a halt sitting in ID.
    always_comb begin
        next_state  = state;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        accept      = 1'b0;
        case (state)
            RUN: begin
                if (ex_br_taken) begin
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (load_use) begin
                    stall_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (id_valid) begin
                    accept = 1'b1;
                    if (id_is_hlt) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                stall_if_id = 1'b1;
                bubble_ex   = 1'b1;
                if (drain_cnt == CNT_W'(2)) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                stall_if_id = 1'b1;
                bubble_ex   = 1'b1;
            end
            default: next_state = RUN;
        endcase
    end

    // Scoreboard shift, registered forward selects and the drain countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb[i] <= '0;
            end
            drain_cnt   <= '0;
            fwd_sel0_ex <= '0;
            fwd_sel1_ex <= '0;
            hlt         <= 1'b0;
        end else begin
            sb[0] <= accept ? id_entry : '0;
            for (int i = 1; i < DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
            fwd_sel0_ex <= (accept && hit0) ? k0 + FS_W'(FWD_NEAREST) : FS_W'(FWD_REGFILE);
            fwd_sel1_ex <= (accept && hit1) ? k1 + FS_W'(FWD_NEAREST) : FS_W'(FWD_REGFILE);
            hlt         <= (next_state == HALTED);
            if (accept && id_is_hlt) begin
                drain_cnt <= CNT_W'(DEPTH);
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard with the default DEPTH and
// a second DEPTH=5 instance sharing the same stimulus.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_src0_addr, id_src1_addr, id_dst_addr;
    logic       id_src0_used, id_src1_used;
    logic       id_we, id_is_load, id_is_hlt, ex_br_taken;

    logic       stall_if_id, bubble_ex, flush_if_id, hlt;
    logic [1:0] fwd_sel0_ex, fwd_sel1_ex;
    logic       stall5, bubble5, flush5, hlt5;
    logic [2:0] fwd0_5, fwd1_5;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       valid;
        logic [3:0] s0, s1;
        logic       u0, u1;
        logic [3:0] dst;
        logic       we, ld, hl, br;
        logic       x_stall, x_bubble, x_flush;
        int         x_f0, x_f1;
        logic       x_hlt;
    } vec_t;

    vec_t tbl[$];
    int   exp5[7] = '{0, 0, 1, 2, 3, 4, 0};
    int   exp3[7] = '{0, 0, 1, 2, 0, 0, 0};

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
        .id_src0_used(id_src0_used), .id_src1_used(id_src1_used),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_is_load(id_is_load),
        .id_is_hlt(id_is_hlt), .ex_br_taken(ex_br_taken),
        .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
        .fwd_sel0_ex(fwd_sel0_ex), .fwd_sel1_ex(fwd_sel1_ex), .hlt(hlt)
    );

    hazard_scoreboard #(.DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
        .id_src0_used(id_src0_used), .id_src1_used(id_src1_used),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_is_load(id_is_load),
        .id_is_hlt(id_is_hlt), .ex_br_taken(ex_br_taken),
        .stall_if_id(stall5), .bubble_ex(bubble5), .flush_if_id(flush5),
        .fwd_sel0_ex(fwd0_5), .fwd_sel1_ex(fwd1_5), .hlt(hlt5)
    );

    always #5 clk = ~clk;

    function automatic void add(string name, bit valid, int s0, int s1, bit u0, bit u1,
                                int dst, bit we, bit ld, bit hl, bit br,
                                bit xs, bit xb, bit xf, int f0, int f1, bit xh);
        vec_t v;
        v.name = name;  v.valid = valid;
        v.s0 = 4'(s0);  v.s1 = 4'(s1);  v.u0 = u0;  v.u1 = u1;
        v.dst = 4'(dst); v.we = we;  v.ld = ld;  v.hl = hl;  v.br = br;
        v.x_stall = xs; v.x_bubble = xb; v.x_flush = xf;
        v.x_f0 = f0;    v.x_f1 = f1;     v.x_hlt = xh;
        tbl.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        id_valid     = v.valid;
        id_src0_addr = v.s0;
        id_src1_addr = v.s1;
        id_src0_used = v.u0;
        id_src1_used = v.u1;
        id_dst_addr  = v.dst;
        id_we        = v.we;
        id_is_load   = v.ld;
        id_is_hlt    = v.hl;
        ex_br_taken  = v.br;
    endtask

    task automatic driveIdle();
        vec_t v;
        v.name = "idle"; v.valid = 0; v.s0 = 0; v.s1 = 0; v.u0 = 0; v.u1 = 0;
        v.dst = 0; v.we = 0; v.ld = 0; v.hl = 0; v.br = 0;
        applyStimulus(v);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput($sformatf("%s.stall", v.name), int'(stall_if_id), int'(v.x_stall));
        checkOutput($sformatf("%s.bubble", v.name), int'(bubble_ex), int'(v.x_bubble));
        checkOutput($sformatf("%s.flush", v.name), int'(flush_if_id), int'(v.x_flush));
        checkOutput($sformatf("%s.fwd0", v.name), int'(fwd_sel0_ex), v.x_f0);
        checkOutput($sformatf("%s.fwd1", v.name), int'(fwd_sel1_ex), v.x_f1);
        checkOutput($sformatf("%s.hlt", v.name), int'(hlt), int'(v.x_hlt));
    endtask

    task automatic checkQuiet(input string name);
        checkOutput($sformatf("%s.stall", name), int'(stall_if_id), 0);
        checkOutput($sformatf("%s.bubble", name), int'(bubble_ex), 0);
        checkOutput($sformatf("%s.flush", name), int'(flush_if_id), 0);
        checkOutput($sformatf("%s.fwd0", name), int'(fwd_sel0_ex), 0);
        checkOutput($sformatf("%s.fwd1", name), int'(fwd_sel1_ex), 0);
        checkOutput($sformatf("%s.hlt", name), int'(hlt), 0);
        checkOutput($sformatf("%s.d5_stall", name), int'(stall5), 0);
        checkOutput($sformatf("%s.d5_fwd0", name), int'(fwd0_5), 0);
        checkOutput($sformatf("%s.d5_fwd1", name), int'(fwd1_5), 0);
        checkOutput($sformatf("%s.d5_hlt", name), int'(hlt5), 0);
    endtask

    initial begin
        // Each row is one cycle; registered expectations reflect the previous row.
        //   name            vld s0  s1 u0 u1 dst we ld hl br  st bu fl f0 f1 hl
        add("add_r1",         1,  3,  4, 1, 1,  1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add("sub_use_r1",     1,  1,  6, 1, 1,  5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add("and_use_r1",     1, 10,  1, 1, 1,  9, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        add("or_wb_r1",       1,  1, 12, 1, 1, 11, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0);
        add("idle0",          0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add("lw_r2",          1, 12,  0, 1, 0,  2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add("add_r2_stall",   1,  2,  2, 1, 1, 13, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        add("add_r2_go",      1,  2,  2, 1, 1, 13, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add("idle1",          0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 2, 2, 0);
        add("lw_r0",          1, 14,  0, 1, 0,  0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add("use_r0",         1,  0,  0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add("idle2",          0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add("lw_r3",          1,  4,  0, 1, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add("br_over_ld",     1,  3,  7, 1, 1,  5, 1, 0, 0, 1,  0, 1, 1, 0, 0, 0);
        add("after_flush",    1,  5,  3, 1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add("idle3",          0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0);
        add("hlt_br",         1,  0,  0, 0, 0,  0, 0, 0, 1, 1,  0, 1, 1, 0, 0, 0);
        add("idle4",          0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        add("hlt_go",         1,  0,  0, 0, 0,  6, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        add("drain1",         1,  6,  0, 1, 0,  7, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
        add("drain_br",       1,  0,  0, 0, 0,  0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0);
        add("halted",         0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 1);
        add("halted_br",      0,  0,  0, 0, 0,  0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 1);

        rst = 1'b1;
        driveIdle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkQuiet("reset");

        foreach (tbl[i]) begin
            @(posedge clk);
            #1 applyStimulus(tbl[i]);
            @(negedge clk);
            checkVector(tbl[i]);
        end

        // Reset out of HALTED, then again in the middle of a drain.
        @(posedge clk);
        #1 rst = 1'b1;
        driveIdle();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkQuiet("rst_halted");

        @(posedge clk);
        #1 begin
            driveIdle();
            id_valid  = 1'b1;
            id_is_hlt = 1'b1;
        end
        @(negedge clk);
        checkOutput("rd_hlt_accept.stall", int'(stall_if_id), 0);
        @(posedge clk);
        #1 driveIdle();
        @(negedge clk);
        checkOutput("rd_drain.stall", int'(stall_if_id), 1);
        checkOutput("rd_drain.hlt", int'(hlt), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkQuiet("rst_drain");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("post_rst%0d.hlt", i), int'(hlt), 0);
            checkOutput($sformatf("post_rst%0d.stall", i), int'(stall_if_id), 0);
        end

        // One producer of R1 followed by five consumers: DEPTH=5 forwards 1..4.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1 begin
                driveIdle();
                if (i == 0) begin
                    id_valid = 1'b1; id_src0_addr = 4'd2; id_src1_addr = 4'd3;
                    id_src0_used = 1'b1; id_src1_used = 1'b1;
                    id_dst_addr = 4'd1; id_we = 1'b1;
                end else if (i < 6) begin
                    id_valid = 1'b1; id_src0_addr = 4'd1; id_src0_used = 1'b1;
                end
            end
            @(negedge clk);
            checkOutput($sformatf("d5_fwd%0d.sel0", i), int'(fwd0_5), exp5[i]);
            checkOutput($sformatf("d3_fwd%0d.sel0", i), int'(fwd_sel0_ex), exp3[i]);
            checkOutput($sformatf("d5_fwd%0d.stall", i), int'(stall5), 0);
            checkOutput($sformatf("d3_fwd%0d.stall", i), int'(stall_if_id), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
